uart_tx: RTL and testbench

UART transmitter that serialises parallel bytes onto the `tx` line as start, data (LSB first), optional parity and stop bits. It is the transmit-side counterpart of the UART receiver. It is timed by the same 16x oversampled `s_tick` pulse from the baud generator, so one bit lasts `SAMPLE_CONST` ticks at every selected baud rate. A one-entry holding register allows back-to-back frames with no idle gap.

---
 rtl/uart_tx.sv | 135 +++++++++++++
 tb/tb_uart_tx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit(s), paced by the oversampled s_tick.
// Latency: accept to start-bit edge is 2 clocks when idle; each bit lasts SAMPLE_CONST ticks.
// Backpressure: tx_ready drops while the one-entry holding register is full; the next byte queues during a frame.
module uart_tx #(
  parameter int DATA_BITS    = 8,
  parameter int SAMPLE_CONST = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);
  localparam int TW = (SAMPLE_CONST > 1) ? $clog2(SAMPLE_CONST) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_CONST - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic [DATA_BITS-1:0] hold_data;
  logic [DATA_BITS-1:0] shift;
  logic                 hold_full;
  logic                 parity_bit;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_cnt;
  logic                 bit_end;
  logic                 load_par;

  assign tx_ready = ~hold_full;
  assign bit_end  = s_tick && (tick_cnt == TICK_LAST);
  assign load_par = (^hold_data) ^ PAR_ODD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold_data  <= '0;
      shift      <= '0;
      hold_full  <= 1'b0;
      parity_bit <= 1'b0;
      tick_cnt   <= '0;
      bit_idx    <= '0;
      stop_cnt   <= 1'b0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      // Accept and load are mutually exclusive: accept needs !hold_full, load needs hold_full.
      if (tx_valid && !hold_full) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end
      if (s_tick) tick_cnt <= bit_end ? '0 : tick_cnt + TW'(1);

      case (state)
        IDLE: begin
          tick_cnt <= '0;
          if (hold_full) begin
            shift      <= hold_data;
            parity_bit <= load_par;
            hold_full  <= 1'b0;
            state      <= START;
            tx         <= 1'b0;
            tx_busy    <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= shift[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            shift <= shift >> 1;
            if (bit_idx == BIT_LAST) begin
              if (PARITY_EN != 0) begin
                state <= PARITY;
                tx    <= parity_bit;
              end else begin
                state    <= STOP;
                stop_cnt <= 1'b0;
                tx       <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + BW'(1);
              tx      <= shift[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (stop_cnt == STOP_LAST) begin
              tx_done <= 1'b1;
              // A queued byte starts its start bit on the very cycle this frame finishes.
              if (hold_full) begin
                shift      <= hold_data;
                parity_bit <= load_par;
                hold_full  <= 1'b0;
                state      <= START;
                tx         <= 1'b0;
              end else begin
                state   <= IDLE;
                tx_busy <= 1'b0;
              end
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four parameter variants share clock, reset and tick.
// A line monitor decodes frames tick-exactly and checks them against a queue of expected frames.
module tb_uart_tx;
  logic       clk = 1'b0;
  logic       rst;
  logic       s_tick;
  logic       tick_en;
  logic [7:0] tx_data;
  logic [3:0] valid_l;
  logic [3:0] ready_l, tx_l, busy_l, done_l;

  int   n_checks = 0;
  int   n_pass = 0;
  int   frames_done = 0;
  int   b2b_cnt = 0;
  int   done_cnt = 0;
  int   mon_sel = 0;
  int   mon_nbits = 10;
  logic mon_en;

  typedef struct { logic [11:0] bits; int nbits; } frame_t;
  typedef struct { int sel; logic [7:0] data; int nbits; logic [11:0] frame; } vec_t;
  frame_t exp_q[$];

  always #5 clk = ~clk;

  uart_tx u_8n1 (.clk(clk), .rst(rst), .s_tick(s_tick), .tx_data(tx_data), .tx_valid(valid_l[0]),
                 .tx_ready(ready_l[0]), .tx(tx_l[0]), .tx_busy(busy_l[0]), .tx_done(done_l[0]));
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u_8e1 (.clk(clk), .rst(rst), .s_tick(s_tick), .tx_data(tx_data),
                 .tx_valid(valid_l[1]), .tx_ready(ready_l[1]), .tx(tx_l[1]), .tx_busy(busy_l[1]), .tx_done(done_l[1]));
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u_8o1 (.clk(clk), .rst(rst), .s_tick(s_tick), .tx_data(tx_data),
                 .tx_valid(valid_l[2]), .tx_ready(ready_l[2]), .tx(tx_l[2]), .tx_busy(busy_l[2]), .tx_done(done_l[2]));
  uart_tx #(.STOP_BITS(2)) u_8n2 (.clk(clk), .rst(rst), .s_tick(s_tick), .tx_data(tx_data),
                 .tx_valid(valid_l[3]), .tx_ready(ready_l[3]), .tx(tx_l[3]), .tx_busy(busy_l[3]), .tx_done(done_l[3]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Tick every 4 clocks, driven 1 time unit after the rising edge.
  initial begin
    int div;
    div = 0;
    s_tick = 1'b0;
    forever begin
      @(posedge clk); #1;
      div = (div + 1) % 4;
      s_tick = tick_en && (div == 0);
    end
  end

  always @(negedge clk) if (done_l[0] === 1'b1) done_cnt++;

  // Decode one frame (and any frame chained back-to-back after it) from the selected DUT.
  task automatic run_frame();
    bit          chain, first, bad, early;
    int          nt, cur, lim, guard, nb;
    logic [11:0] got, mask;
    frame_t      ef;
    chain = 1'b1;
    while (chain) begin
      nt = 0; cur = -1; guard = 0; bad = 1'b0; early = 1'b0; first = 1'b1;
      got = '1; mask = '0;
      nb = mon_nbits;
      lim = 16 * nb;
      while (nt < lim && guard < 6000) begin
        if (nt / 16 != cur) begin
          cur = nt / 16;
          got[cur] = tx_l[mon_sel];
        end else if (tx_l[mon_sel] !== got[cur]) bad = 1'b1;
        if (!first && done_l[mon_sel] === 1'b1) early = 1'b1;
        first = 1'b0;
        if (s_tick) nt++;
        guard++;
        @(negedge clk);
      end
      check("frame_in_time", guard < 6000, 1);
      check("frame_done_pulse", done_l[mon_sel], 1);
      check("frame_no_early_done", early, 0);
      check("frame_bit_stable", bad, 0);
      check("frame_queued", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        ef = exp_q.pop_front();
        for (int i = 0; i < nb; i++) mask[i] = 1'b1;
        check("frame_bits", got & mask, ef.bits);
        check("frame_len", nb, ef.nbits);
      end
      frames_done++;
      chain = (guard < 6000) && (tx_l[mon_sel] === 1'b0);
      if (chain) b2b_cnt++;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !rst && tx_l[mon_sel] === 1'b0) run_frame();
    end
  end

  task automatic send(input int k, input logic [7:0] d);
    int n;
    n = 0;
    while (ready_l[k] !== 1'b1 && n < 5000) begin @(posedge clk); #1; n++; end
    check("send_ready", ready_l[k], 1);
    tx_data = d;
    valid_l[k] = 1'b1;
    @(posedge clk); #1;
    valid_l[k] = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (frames_done < target && n < 4000) begin @(posedge clk); #1; n++; end
    check("frames_seen", frames_done, target);
  endtask

  initial begin
    vec_t   vecs[8];
    frame_t f;
    logic   tx_s, moved, busy_drop, tx_low;
    int     d0;

    // Frame bits listed start-bit first (bit 0 = start).
    vecs[0] = '{sel: 0, data: 8'hA5, nbits: 10, frame: 12'h34A};
    vecs[1] = '{sel: 0, data: 8'h00, nbits: 10, frame: 12'h200};
    vecs[2] = '{sel: 0, data: 8'hFF, nbits: 10, frame: 12'h3FE};
    vecs[3] = '{sel: 1, data: 8'h07, nbits: 11, frame: 12'h60E};
    vecs[4] = '{sel: 2, data: 8'h07, nbits: 11, frame: 12'h40E};
    vecs[5] = '{sel: 1, data: 8'h03, nbits: 11, frame: 12'h406};
    vecs[6] = '{sel: 2, data: 8'h00, nbits: 11, frame: 12'h600};
    vecs[7] = '{sel: 3, data: 8'hFF, nbits: 11, frame: 12'h7FE};

    rst = 1'b1; tick_en = 1'b1; valid_l = '0; tx_data = '0; mon_en = 1'b1;
    #2;
    check("rst_tx", tx_l[0], 1);
    check("rst_ready", ready_l[0], 1);
    check("rst_busy", busy_l[0], 0);
    check("rst_done", done_l[0], 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      mon_sel = vecs[i].sel;
      mon_nbits = vecs[i].nbits;
      f.bits = vecs[i].frame;
      f.nbits = vecs[i].nbits;
      exp_q.push_back(f);
      send(vecs[i].sel, vecs[i].data);
      wait_frames(i + 1);
    end

    // Accept timing from idle, then a second byte queued mid-frame for back-to-back output.
    mon_sel = 0; mon_nbits = 10;
    f.bits = 12'h2AA; f.nbits = 10; exp_q.push_back(f);
    send(0, 8'h55);
    @(negedge clk);
    check("acc_n1_ready", ready_l[0], 0);
    check("acc_n1_tx", tx_l[0], 1);
    check("acc_n1_busy", busy_l[0], 0);
    @(negedge clk);
    check("acc_n2_tx", tx_l[0], 0);
    check("acc_n2_busy", busy_l[0], 1);
    check("acc_n2_ready", ready_l[0], 1);
    repeat (100) @(posedge clk);
    #1;
    f.bits = 12'h21E; f.nbits = 10; exp_q.push_back(f);
    send(0, 8'h0F);
    @(negedge clk);
    check("b2b_ready_low", ready_l[0], 0);
    check("b2b_busy", busy_l[0], 1);
    @(posedge clk); #1;
    wait_frames(10);
    check("b2b_chained", b2b_cnt, 1);
    check("done_count", done_cnt, 5);

    // Tick stall mid-DATA.
    f.bits = 12'h32C; f.nbits = 10; exp_q.push_back(f);
    send(0, 8'h96);
    repeat (200) @(posedge clk);
    #1 tick_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 tx_s = tx_l[0];
    moved = 1'b0; busy_drop = 1'b0;
    repeat (1000) begin
      @(posedge clk); #1;
      if (tx_l[0] !== tx_s) moved = 1'b1;
      if (busy_l[0] !== 1'b1) busy_drop = 1'b1;
    end
    check("stall_tx_held", moved, 0);
    check("stall_busy_held", busy_drop, 0);
    tick_en = 1'b1;
    wait_frames(11);

    // Reset mid-frame with a byte pending.
    mon_en = 1'b0;
    send(0, 8'h3C);
    repeat (100) @(posedge clk);
    #1;
    send(0, 8'h11);
    check("hold_ready_low", ready_l[0], 0);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("mid_rst_tx", tx_l[0], 1);
    check("mid_rst_busy", busy_l[0], 0);
    check("mid_rst_ready", ready_l[0], 1);
    check("mid_rst_done", done_l[0], 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tx_low = 1'b0; busy_drop = 1'b0;
    repeat (300) begin
      @(posedge clk); #1;
      if (tx_l[0] !== 1'b1) tx_low = 1'b1;
      if (busy_l[0] !== 1'b0) busy_drop = 1'b1;
    end
    check("post_rst_idle_tx", tx_low, 0);
    check("post_rst_not_busy", busy_drop, 0);
    check("post_rst_no_done", done_cnt, d0);
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
